// File: rtl/mvm_pkg.sv
// Shared types and defaults for the matrix-vector multiply sequencer.
// Optional performance counter in mvm_seq_ctrl is enabled by MVM_PERF_CNT_EN.
package mvm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        MAC,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    localparam int MVM_ROWS_DEF    = 4;
    localparam int MVM_COLS_DEF    = 4;
    localparam int MVM_MEM_LAT_DEF = 1;

    // Address ports must stay at least one bit wide even for single-entry memories.
    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/mvm_rd_pipe.sv
// Read-valid delay line: turns the memory read strobe into the accumulate
// enable that lines up with returning data LAT cycles later.
module mvm_rd_pipe #(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_vld,
    output logic o_vld
);

    logic [LAT-1:0] r_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr <= '0;
        end else begin
            r_sr[0] <= i_vld;
            for (int i = 1; i < LAT; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign o_vld = r_sr[LAT-1];

endmodule

// File: rtl/mvm_seq_ctrl.sv
// Address/strobe sequencer for a row-major matrix-vector multiply.
// Define MVM_PERF_CNT_EN to add the 16-bit busy-cycle counter output perf_cycles.
module mvm_seq_ctrl
    import mvm_pkg::*;
#(
    parameter int ROWS    = MVM_ROWS_DEF,
    parameter int COLS    = MVM_COLS_DEF,
    parameter int MEM_LAT = MVM_MEM_LAT_DEF,
    parameter int MAT_AW  = clog2_min1(ROWS * COLS),
    parameter int VEC_AW  = clog2_min1(COLS),
    parameter int RES_AW  = clog2_min1(ROWS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
`ifdef MVM_PERF_CNT_EN
    output logic [15:0]       perf_cycles,
`endif
    output logic              mat_rd,
    output logic [MAT_AW-1:0] mat_addr,
    output logic              vec_rd,
    output logic [VEC_AW-1:0] vec_addr,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              res_we,
    output logic [RES_AW-1:0] res_addr
);

    state_t              r_state;
    logic [RES_AW-1:0]   r_row;
    logic [VEC_AW-1:0]   r_col;
    logic [2:0]          r_lat;
    logic                r_busy;
    logic                r_done;
    logic                r_mat_rd;
    logic [MAT_AW-1:0]   r_mat_addr;
    logic                r_acc_clr;
    logic                r_res_we;
    logic [MAT_AW-1:0]   w_row_base;
    logic                w_acc_en;

    assign w_row_base = MAT_AW'(r_row) * MAT_AW'(COLS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_row      <= '0;
            r_col      <= '0;
            r_lat      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mat_rd   <= 1'b0;
            r_mat_addr <= '0;
            r_acc_clr  <= 1'b0;
            r_res_we   <= 1'b0;
        end else begin
            r_acc_clr <= 1'b0;
            r_res_we  <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= CLEAR;
                        r_busy    <= 1'b1;
                        r_acc_clr <= 1'b1;
                        r_col     <= '0;
                    end
                end
                CLEAR: begin
                    r_state    <= MAC;
                    r_mat_rd   <= 1'b1;
                    r_mat_addr <= w_row_base;
                end
                MAC: begin
                    if (r_col == VEC_AW'(COLS - 1)) begin
                        r_state  <= DRAIN;
                        r_mat_rd <= 1'b0;
                        r_lat    <= '0;
                    end else begin
                        r_col      <= r_col + VEC_AW'(1);
                        r_mat_addr <= r_mat_addr + MAT_AW'(1);
                    end
                end
                // Hold off the write until the last read's data has been accumulated.
                DRAIN: begin
                    if (r_lat == 3'(MEM_LAT - 1)) begin
                        r_state  <= WRITE;
                        r_res_we <= 1'b1;
                    end else begin
                        r_lat <= r_lat + 3'd1;
                    end
                end
                WRITE: begin
                    if (r_row == RES_AW'(ROWS - 1)) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_row   <= '0;
                    end else begin
                        r_state   <= CLEAR;
                        r_row     <= r_row + RES_AW'(1);
                        r_acc_clr <= 1'b1;
                        r_col     <= '0;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    mvm_rd_pipe #(
        .LAT(MEM_LAT)
    ) u_rd_pipe (
        .clk  (clk),
        .rst_n(rst),
        .i_vld(r_mat_rd),
        .o_vld(w_acc_en)
    );

`ifdef MVM_PERF_CNT_EN
    logic [15:0] r_perf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf <= '0;
        end else if (r_state == IDLE && start) begin
            r_perf <= '0;
        end else if (r_busy && r_perf != 16'hFFFF) begin
            r_perf <= r_perf + 16'd1;
        end
    end

    assign perf_cycles = r_perf;
`endif

    assign busy     = r_busy;
    assign done     = r_done;
    assign mat_rd   = r_mat_rd;
    assign vec_rd   = r_mat_rd;
    assign mat_addr = r_mat_addr;
    assign vec_addr = r_col;
    assign acc_clr  = r_acc_clr;
    assign acc_en   = w_acc_en;
    assign res_we   = r_res_we;
    assign res_addr = r_row;

endmodule

// File: tb/tb_mvm_seq_ctrl.sv
// Bench for mvm_seq_ctrl: three parameter sets driven side by side against a
// cycle-position reference model. Perf counter checks follow MVM_PERF_CNT_EN.
module tb_mvm_seq_ctrl;

    localparam int NDUT = 3;

    function automatic int cfg_rows(input int i);
        case (i)
            0: return 4;
            1: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int cfg_cols(input int i);
        case (i)
            0: return 4;
            1: return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int cfg_lat(input int i);
        case (i)
            0: return 1;
            1: return 3;
            default: return 1;
        endcase
    endfunction

    logic clk;
    logic rst;
    logic [NDUT-1:0] start_v;

    logic [NDUT-1:0][6:0]  obs_strb;
    logic [NDUT-1:0][31:0] obs_mat;
    logic [NDUT-1:0][31:0] obs_vec;
    logic [NDUT-1:0][31:0] obs_res;
    logic [NDUT-1:0][15:0] obs_perf;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t       [NDUT];
    int acc_cyc [NDUT];
    int exp_perf[NDUT];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        localparam int R   = cfg_rows(gi);
        localparam int C   = cfg_cols(gi);
        localparam int L   = cfg_lat(gi);
        localparam int MAW = mvm_pkg::clog2_min1(R * C);
        localparam int VAW = mvm_pkg::clog2_min1(C);
        localparam int RAW = mvm_pkg::clog2_min1(R);

        logic busy, done, mat_rd, vec_rd, acc_clr, acc_en, res_we;
        logic [MAW-1:0] mat_addr;
        logic [VAW-1:0] vec_addr;
        logic [RAW-1:0] res_addr;
        logic [15:0]    perf_cycles;

        mvm_seq_ctrl #(
            .ROWS(R), .COLS(C), .MEM_LAT(L)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start_v[gi]),
            .busy       (busy),
            .done       (done),
`ifdef MVM_PERF_CNT_EN
            .perf_cycles(perf_cycles),
`endif
            .mat_rd     (mat_rd),
            .mat_addr   (mat_addr),
            .vec_rd     (vec_rd),
            .vec_addr   (vec_addr),
            .acc_clr    (acc_clr),
            .acc_en     (acc_en),
            .res_we     (res_we),
            .res_addr   (res_addr)
        );

`ifndef MVM_PERF_CNT_EN
        assign perf_cycles = 16'd0;
`endif
        assign obs_strb[gi] = {busy, done, mat_rd, vec_rd, acc_clr, acc_en, res_we};
        assign obs_mat[gi]  = 32'(mat_addr);
        assign obs_vec[gi]  = 32'(vec_addr);
        assign obs_res[gi]  = 32'(res_addr);
        assign obs_perf[gi] = perf_cycles;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected strobes {busy,done,mat_rd,vec_rd,acc_clr,acc_en,res_we} at cycle tt of a run
    // (tt=1 is the cycle after the accepting edge, tt=0 means idle).
    function automatic logic [6:0] exp_strb(input int i, input int tt);
        int c, l, per, p;
        logic [6:0] s;
        c   = cfg_cols(i);
        l   = cfg_lat(i);
        per = c + l + 2;
        s   = '0;
        if (tt == 0) return s;
        if (tt == cfg_rows(i) * per + 1) return 7'b0100000;
        p    = (tt - 1) % per;
        s[6] = 1'b1;
        s[4] = (p >= 1 && p <= c);
        s[3] = (p >= 1 && p <= c);
        s[2] = (p == 0);
        s[1] = (p >= l + 1 && p <= c + l);
        s[0] = (p == c + l + 1);
        return s;
    endfunction

    function automatic int run_len(input int i);
        return cfg_rows(i) * (cfg_cols(i) + cfg_lat(i) + 2);
    endfunction

    // Reference model advance on each edge, then check every DUT 1 ns later.
    always begin
        @(posedge clk);
        cyc++;
        for (int i = 0; i < NDUT; i++) begin
            int prev;
            prev = t[i];
            if (!rst) begin
                t[i] = 0;
                exp_perf[i] = 0;
            end else if (prev == 0) begin
                if (start_v[i]) begin
                    t[i] = 1;
                    acc_cyc[i] = cyc;
                    exp_perf[i] = 0;
                end
            end else begin
                if (prev <= run_len(i) && exp_perf[i] < 16'hFFFF) exp_perf[i]++;
                t[i] = (prev + 1 > run_len(i) + 1) ? 0 : prev + 1;
            end
        end
        #1;
        for (int i = 0; i < NDUT; i++) begin
            logic [6:0] e;
            int per, p;
            e   = exp_strb(i, t[i]);
            per = cfg_cols(i) + cfg_lat(i) + 2;
            p   = (t[i] - 1) % per;
            check($sformatf("d%0d strobes t=%0d", i, t[i]), 32'(obs_strb[i]), 32'(e));
            if (e[4]) begin
                check($sformatf("d%0d mat_addr t=%0d", i, t[i]), obs_mat[i],
                      32'(((t[i] - 1) / per) * cfg_cols(i) + p - 1));
                check($sformatf("d%0d vec_addr t=%0d", i, t[i]), obs_vec[i], 32'(p - 1));
            end
            if (e[0]) begin
                check($sformatf("d%0d res_addr t=%0d", i, t[i]), obs_res[i], 32'((t[i] - 1) / per));
            end
            if (obs_strb[i][5]) begin
                check($sformatf("d%0d done latency", i), 32'(cyc - acc_cyc[i]), 32'(run_len(i)));
            end
`ifdef MVM_PERF_CNT_EN
            check($sformatf("d%0d perf t=%0d", i, t[i]), 32'(obs_perf[i]), 32'(exp_perf[i]));
`endif
        end
    end

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("%s d%0d strobes", tag, i), 32'(obs_strb[i]), 32'd0);
            check($sformatf("%s d%0d addrs", tag, i), obs_mat[i] | obs_vec[i] | obs_res[i], 32'd0);
        end
    endtask

    task automatic pulse_start(input logic [NDUT-1:0] m);
        @(negedge clk);
        start_v = m;
        @(negedge clk);
        start_v = '0;
    endtask

    initial begin
        int  p0;
        bit  found;
        for (int i = 0; i < NDUT; i++) begin
            t[i] = 0;
            acc_cyc[i] = 0;
            exp_perf[i] = 0;
        end
        rst     = 1'b0;
        start_v = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;

        // One start pulse on every configuration.
        pulse_start('1);
        repeat (40) @(negedge clk);

        // start held high: one run, ignored while busy, re-accepted after DONE.
        @(negedge clk);
        start_v = '1;
        repeat (40) @(negedge clk);
        start_v = '0;
        repeat (40) @(negedge clk);

        // Random start traffic.
        repeat (400) begin
            @(negedge clk);
            for (int i = 0; i < NDUT; i++) start_v[i] = ($urandom_range(0, 3) == 0);
        end
        start_v = '0;
        repeat (40) @(negedge clk);

        // Asynchronous reset in the middle of row 2's MAC phase.
        pulse_start('1);
        p0    = cfg_cols(0) + cfg_lat(0) + 2;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(posedge clk);
            #2;
            if (t[0] == 2 * p0 + 2) found = 1'b1;
        end
        check("wait mac row2", 32'(found), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check_all_zero("async reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Fresh run after the aborted one.
        pulse_start('1);
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mvm_seq_ctrl.md
Name: mvm_seq_ctrl

Overview:
- Sequencing controller for the matrix-vector multiply datapath under `top`.
- Accepts a start pulse, walks a row-major ROWS×COLS matrix memory and a COLS-entry vector memory, and drives the accumulator clear/enable strobes.
- Writes one result per row and pulses done when the whole product is complete.
- Carries no data; addresses and strobes only.

Parameters:
- ROWS, 4, matrix rows = number of result entries (≥1).
- COLS, 4, matrix columns = vector length (≥1).
- MEM_LAT, 1, read latency of the matrix/vector memories in cycles (1..4).
- MAT_AW, $clog2(ROWS*COLS) (min 1), matrix address width.
- VEC_AW, $clog2(COLS) (min 1), vector address width.
- RES_AW, $clog2(ROWS) (min 1), result address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  request; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done is asserted.
- done  out  1  one-cycle completion pulse.
- mat_rd  out  1  matrix read strobe.
- mat_addr  out  MAT_AW  matrix address = row*COLS+col.
- vec_rd  out  1  vector read strobe; always equal to mat_rd.
- vec_addr  out  VEC_AW  vector address = col.
- acc_clr  out  1  clear accumulator.
- acc_en  out  1  accumulate the current product (data valid).
- res_we  out  1  result write strobe.
- res_addr  out  RES_AW  result address = row.

Behaviour:
- Clock and reset: one clock domain, clk. rst is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, row=0, col=0, read-valid delay line cleared.
- FSM states: IDLE, CLEAR, MAC, DRAIN, WRITE, DONE.
- IDLE: start=1 at an edge → CLEAR. Otherwise stay in IDLE.
- CLEAR (1 cycle): acc_clr=1, col=0 → MAC.
- MAC (COLS cycles):
  - mat_rd=vec_rd=1, mat_addr=row*COLS+col, vec_addr=col.
  - col increments each cycle.
  - At col=COLS-1 → DRAIN.
- DRAIN (MEM_LAT cycles): no reads; waits for the last data to return → WRITE.
- WRITE (1 cycle): res_we=1, res_addr=row.
  - If row=ROWS-1 → DONE.
  - Otherwise row+1 → CLEAR.
- DONE (1 cycle): done=1, busy=0, row=0 → IDLE.
- acc_en:
  - Equals mat_rd delayed by exactly MEM_LAT cycles, via a shift register.
  - Exactly COLS acc_en cycles occur per row.
  - The last acc_en falls in the final DRAIN cycle.
  - The first acc_en occurs at least one cycle after acc_clr.
- Latency: done is high in the cycle following edge ROWS*(COLS+MEM_LAT+2) counted from the start-accept edge (edge 0). Defaults give 28.
- Strobe exclusivity: acc_clr, res_we and done are mutually exclusive. res_we never coincides with acc_en.
- start outside IDLE (busy, or in DONE) is ignored and not queued. start still high on the IDLE cycle after DONE begins a new run.
- Counter widths: row counter width RES_AW, col counter width VEC_AW. No wrap is possible; terminal compares use ROWS-1 and COLS-1.
- Degenerate sizes: COLS=1 gives a one-cycle MAC. ROWS=1 goes directly to DONE after the first WRITE.
- Reset mid-operation: immediate return to the reset values. In-flight acc_en pulses are discarded. No res_we or done is emitted.

Optional Feature:
- Macro: MVM_PERF_CNT_EN.
- Defined:
  - Adds output perf_cycles (16 bits).
  - Cleared on the start-accept edge; increments every busy cycle, saturating at 16'hFFFF.
  - Holds its value through DONE/IDLE until the next accepted start. Reset value 0.
  - Defaults read 28 at done.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package mvm_pkg:
  - State enum (IDLE, CLEAR, MAC, DRAIN, WRITE, DONE).
  - Default ROWS/COLS/MEM_LAT constants.
  - Helper function for the clamped-minimum-1 $clog2 used by the address widths.
- Sub-module mvm_rd_pipe: MEM_LAT-deep, 1-bit valid shift register (async active-low reset) producing acc_en from mat_rd.
- The FSM and counters stay in mvm_seq_ctrl.

Test Plan:
- Defaults, one start pulse:
  - mat_addr sequence 0..15, with vec_addr 0,1,2,3 repeating.
  - acc_clr 4×, acc_en 16×, res_we 4× at res_addr 0,1,2,3.
  - done one cycle, 28 edges after accept.
- MEM_LAT=3, ROWS=2, COLS=3:
  - acc_en lags each mat_rd by 3 cycles.
  - DRAIN lasts 3 cycles.
  - done at edge 2*(3+3+2)=16.
- start held high for 40 cycles:
  - Exactly one run during busy.
  - A second run starts on the IDLE cycle after done.
  - Pulses during busy are ignored.
- rst driven 0 asynchronously mid-MAC of row 2:
  - All outputs 0 before the next edge.
  - No done; a fresh start produces a full 28-cycle run.
- ROWS=1, COLS=1, MEM_LAT=1: CLEAR, MAC, DRAIN, WRITE, DONE; done at edge 4.
- MVM_PERF_CNT_EN defined, defaults: perf_cycles=28 at done and held; it resets to 0 on the next accepted start.
